// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial_to_parallel receiver.
package s2p_pkg;

    // Default word width and error counter width
    localparam int unsigned S2P_N     = 14;
    localparam int unsigned S2P_ERR_W = 8;

    // State encoding
    localparam logic S2P_HUNT  = 1'b0;
    localparam logic S2P_SHIFT = 1'b1;

    typedef enum logic {
        ST_HUNT  = S2P_HUNT,
        ST_SHIFT = S2P_SHIFT
    } s2p_state_e;

    // Bit-counter width for an n-bit word; never narrower than one bit
    function automatic int unsigned s2p_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input / parallel output bundle for serial_to_parallel.
// err_count exists only when S2P_ERR_CNT_EN is defined.
interface serial_to_parallel_if
    import s2p_pkg::*;
#(
    parameter int unsigned N = S2P_N
) ();

    logic                 data_in;
    logic                 sync_tick;
    logic [N-1:0]         data_out;
    logic                 valid_tick;
    logic                 sync_err;
`ifdef S2P_ERR_CNT_EN
    logic [S2P_ERR_W-1:0] err_count;
`endif

`ifdef S2P_ERR_CNT_EN
    // Stream source / output consumer side
    modport master (
        output data_in,
        output sync_tick,
        input  data_out,
        input  valid_tick,
        input  sync_err,
        input  err_count
    );

    // Deserialiser side
    modport slave (
        input  data_in,
        input  sync_tick,
        output data_out,
        output valid_tick,
        output sync_err,
        output err_count
    );
`else
    // Stream source / output consumer side
    modport master (
        output data_in,
        output sync_tick,
        input  data_out,
        input  valid_tick,
        input  sync_err
    );

    // Deserialiser side
    modport slave (
        input  data_in,
        input  sync_tick,
        output data_out,
        output valid_tick,
        output sync_err
    );
`endif

endinterface

// File: rtl/s2p_err_counter.sv
// Saturating event counter for sync slips.
// Only built when S2P_ERR_CNT_EN is defined; otherwise this file is empty.
`ifdef S2P_ERR_CNT_EN
module s2p_err_counter
    import s2p_pkg::*;
#(
    parameter int unsigned W = S2P_ERR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on each inc, hold at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule
`endif

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel deserialiser with sync_tick word alignment.
// Optional saturating slip counter on err_count: define S2P_ERR_CNT_EN.
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int unsigned N = S2P_N
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_to_parallel_if.slave  bus
);

    localparam int unsigned CW   = s2p_cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    s2p_state_e    state;
    logic [CW-1:0] count;
    // Bits 0..N-2 of the word in progress; bit N-1 goes straight to data_out
    logic [N-2:0]  shift;
    logic [N-1:0]  data_q;
    logic          valid_q;
    logic          err_q;
    logic          slip_c;

    // sync_tick anywhere but bit 0 of a locked word is a realignment
    assign slip_c = (state == ST_SHIFT) && bus.sync_tick && (count != '0);

    // Lock FSM, bit counter, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_HUNT;
            count   <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (bus.sync_tick) begin
                        shift[0] <= bus.data_in;
                        count    <= CW'(1);
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (slip_c) begin
                        // Drop the partial word and restart at bit 0; wins over completion
                        shift[0] <= bus.data_in;
                        count    <= CW'(1);
                        err_q    <= 1'b1;
                    end else if (count == LAST) begin
                        data_q  <= {bus.data_in, shift};
                        valid_q <= 1'b1;
                        count   <= '0;
                    end else begin
                        shift[count] <= bus.data_in;
                        count        <= count + CW'(1);
                    end
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_tick = valid_q;
    assign bus.sync_err   = err_q;

`ifdef S2P_ERR_CNT_EN
    // Slip counter; increments on the same edge that raises sync_err
    s2p_err_counter #(
        .W (S2P_ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (slip_c),
        .count (bus.err_count)
    );
`endif

endmodule
